hazard_unit_mc: RTL and testbench
=================================

# hazard_unit_mc

Parametrised hazard controller for the cached five-stage RISC-V pipeline with a multi-cycle multiply/divide unit (MDU) in Execute. It keeps M-over-W operand forwarding and cache-miss freeze, and adds a multi-cycle load-use stall sequencer, an MDU occupancy FSM, and saturating stall/flush performance counters. It sits beside the pipeline registers and drives all of their stall and flush enables.

## Interface
- REG_W, 5: register index width.
- LOAD_USE_STALL, 1: bubbles inserted per load-use hazard (1..7).
- MDU_LAT, 4: cycles an MDU op occupies Execute (2..15).
- CNT_W, 32: performance counter width.

- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  REG_W  stage register indices.
- RegWriteM, RegWriteW  in  1  destination write enables.
- ResultSrcE  in  2  2'b01 marks a load in Execute.
- PCSrcE  in  2  non-zero means a taken jump/branch in Execute.
- MduStartE  in  1  valid MDU op in Execute; held high while that op stays in E.
- CacheStall  in  1  data-cache miss in progress.
- branch_mispredict_i  in  1  predictor mispredict resolved in Execute.
- ForwardAE, ForwardBE  out  2  00 register file, 10 from M, 01 from W.
- StallFetch, StallDecode, StallExecute, StallMemory  out  1  hold the stage register.
- FlushDecode, FlushExecute, FlushMemory, FlushWriteback  out  1  bubble into the stage register.
- pc_redirect_o  out  1  redirect PC to the corrected target.
- MduBusy  out  1  MDU FSM in BUSY.
- StallCount, FlushCount  out  CNT_W  saturating performance counters.

## Operation
- Forwarding (combinational): if Rs1E==0 then ForwardAE=00; else if Rs1E==RdM and RegWriteM then 10; else if Rs1E==RdW and RegWriteW then 01; else 00. ForwardBE uses Rs2E with the same rules.
- Control priority, highest first: CacheStall, MDU, mispredict, PCSrcE, load-use. All stall/flush/redirect outputs default to 0.
- CacheStall: StallFetch, StallDecode, StallExecute, StallMemory and FlushWriteback are 1. All FSM state, counters and perf counters hold, except StallCount, which increments.
- MDU FSM, IDLE/BUSY, with counter mcnt:
  - IDLE, MduStartE=1: assert StallFetch, StallDecode, StallExecute and FlushMemory. Go to BUSY with mcnt=MDU_LAT-2.
  - BUSY, mcnt!=0: assert the same four outputs; decrement mcnt.
  - BUSY, mcnt==0: no MDU stall; return to IDLE. The op leaves E at the end of this cycle. MduStartE is ignored in BUSY.
  - The op occupies E for exactly MDU_LAT non-frozen cycles, with MDU_LAT-1 stall cycles.
- Mispredict (MDU not stalling): pc_redirect_o, FlushDecode and FlushExecute are 1. Any pending load-use count is cleared. branch_mispredict_i is illegal while MduBusy=1; the bench asserts this.
- PCSrcE!=0: FlushDecode and FlushExecute are 1. Pending load-use count is cleared.
- Load-use sequencer, counter lcnt:
  - Detection: ResultSrcE==01, RdE!=0, and RdE equals Rs1D or Rs2D. On detection, assert StallFetch, StallDecode and FlushExecute, and load lcnt=LOAD_USE_STALL-1.
  - While lcnt!=0, with no higher-priority event: assert the same three outputs and decrement lcnt.
  - Detection is ignored while lcnt!=0.
- Performance counters:
  - StallCount increments each cycle StallFetch=1.
  - FlushCount increments each cycle FlushDecode=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Forwarding and all control outputs are combinational from inputs and current state. FSM state and counters update on rising clk.
- Reset: async assert clears FSM to IDLE, lcnt=0, mcnt=0, StallCount=0, FlushCount=0, MduBusy=0. While rst=1, all stall/flush/redirect outputs are forced 0. Forward outputs stay combinational.
- Load-use detected in cycle t: stall in cycles t..t+LOAD_USE_STALL-1; Decode released at t+LOAD_USE_STALL.
- MduStartE rising in cycle t, no cache stall: MduBusy=1 in cycles t+1..t+MDU_LAT-1; stalls in t..t+MDU_LAT-2.
- CacheStall in the middle of either sequence extends it by exactly the frozen cycles.
- Reset mid-sequence aborts it immediately.

## Test plan
- Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Clear RegWriteM -> 01. Set Rs1E=0 -> 00.
- Load-use with LOAD_USE_STALL=2: ResultSrcE=01, RdE=7, Rs2D=7 at cycle t -> StallFetch and FlushExecute high in t and t+1, low in t+2. StallCount=2.
- MDU with MDU_LAT=4: MduStartE held high from cycle t until the op advances -> StallExecute high for t..t+2, low at t+3; MduBusy high for t+1..t+3; FSM IDLE at t+4.
- CacheStall for 3 cycles during MDU cycle t+1 -> MDU stall window extends by 3 cycles. FlushWriteback high during the freeze. StallCount=6.
- Mispredict and load-use detected together -> pc_redirect_o, FlushDecode and FlushExecute high; StallFetch=0; lcnt=0; FlushCount=1.
- Async rst pulse mid-MDU with mcnt=1 -> outputs drop to 0 immediately, FSM IDLE, counters 0. Preload StallCount to all-ones and stall again -> stays all-ones.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Hazard controller for the cached five-stage pipeline with a multi-cycle MDU:
// operand forwarding, cache freeze, load-use sequencer, MDU occupancy FSM and perf counters.
module hazard_unit_mc #(
  parameter int REG_W          = 5,
  parameter int LOAD_USE_STALL = 1,
  parameter int MDU_LAT        = 4,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic [1:0]       PCSrcE,
  input  logic             MduStartE,
  input  logic             CacheStall,
  input  logic             branch_mispredict_i,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallFetch,
  output logic             StallDecode,
  output logic             StallExecute,
  output logic             StallMemory,
  output logic             FlushDecode,
  output logic             FlushExecute,
  output logic             FlushMemory,
  output logic             FlushWriteback,
  output logic             pc_redirect_o,
  output logic             MduBusy,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  localparam logic [3:0] MCNT_INIT = 4'(MDU_LAT - 2);
  localparam logic [2:0] LCNT_INIT = 3'(LOAD_USE_STALL - 1);

  mdu_state_t       state_reg;
  logic [3:0]       mcnt_reg;
  logic [2:0]       lcnt_reg;
  logic [CNT_W-1:0] stall_count_reg;
  logic [CNT_W-1:0] flush_count_reg;

  logic mdu_stall;
  logic lu_detect;
  logic lu_stall;

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
    if (rs == '0)                    return 2'b00;
    else if (rs == RdM && RegWriteM) return 2'b10;
    else if (rs == RdW && RegWriteW) return 2'b01;
    else                             return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E);
  assign ForwardBE = fwd_sel(Rs2E);

  // MduStartE only matters from IDLE; BUSY stalls until the last occupancy cycle.
  assign mdu_stall = (state_reg == IDLE) ? MduStartE : (mcnt_reg != 4'd0);
  assign lu_detect = (ResultSrcE == 2'b01) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign lu_stall  = (lcnt_reg != 3'd0) || lu_detect;

  assign MduBusy    = (state_reg == BUSY);
  assign StallCount = stall_count_reg;
  assign FlushCount = flush_count_reg;

  always_comb begin
    StallFetch     = 1'b0;
    StallDecode    = 1'b0;
    StallExecute   = 1'b0;
    StallMemory    = 1'b0;
    FlushDecode    = 1'b0;
    FlushExecute   = 1'b0;
    FlushMemory    = 1'b0;
    FlushWriteback = 1'b0;
    pc_redirect_o  = 1'b0;
    if (rst) begin
      StallFetch = 1'b0;
    end else if (CacheStall) begin
      StallFetch     = 1'b1;
      StallDecode    = 1'b1;
      StallExecute   = 1'b1;
      StallMemory    = 1'b1;
      FlushWriteback = 1'b1;
    end else if (mdu_stall) begin
      StallFetch   = 1'b1;
      StallDecode  = 1'b1;
      StallExecute = 1'b1;
      FlushMemory  = 1'b1;
    end else if (branch_mispredict_i) begin
      pc_redirect_o = 1'b1;
      FlushDecode   = 1'b1;
      FlushExecute  = 1'b1;
    end else if (PCSrcE != 2'b00) begin
      FlushDecode  = 1'b1;
      FlushExecute = 1'b1;
    end else if (lu_stall) begin
      StallFetch   = 1'b1;
      StallDecode  = 1'b1;
      FlushExecute = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      mcnt_reg        <= 4'd0;
      lcnt_reg        <= 3'd0;
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      if (StallFetch && (stall_count_reg != '1))
        stall_count_reg <= stall_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      if (FlushDecode && (flush_count_reg != '1))
        flush_count_reg <= flush_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};

      // A cache freeze holds both sequencers so they stretch by the frozen cycles.
      if (!CacheStall) begin
        case (state_reg)
          IDLE: begin
            if (MduStartE) begin
              state_reg <= BUSY;
              mcnt_reg  <= MCNT_INIT;
            end
          end
          BUSY: begin
            if (mcnt_reg != 4'd0)
              mcnt_reg <= mcnt_reg - 4'd1;
            else
              state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase

        if (!mdu_stall) begin
          if (branch_mispredict_i || (PCSrcE != 2'b00))
            lcnt_reg <= 3'd0;
          else if (lcnt_reg != 3'd0)
            lcnt_reg <= lcnt_reg - 3'd1;
          else if (lu_detect)
            lcnt_reg <= LCNT_INIT;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: forwarding, load-use, MDU, cache freeze,
// mispredict, async reset and counter saturation with hand-computed expectations.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE, PCSrcE;
  logic       MduStartE, CacheStall, branch_mispredict_i;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallFetch, StallDecode, StallExecute, StallMemory;
  logic       FlushDecode, FlushExecute, FlushMemory, FlushWriteback;
  logic       pc_redirect_o, MduBusy;
  logic [3:0] StallCount, FlushCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(
    .REG_W(5), .LOAD_USE_STALL(2), .MDU_LAT(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MduStartE(MduStartE), .CacheStall(CacheStall),
    .branch_mispredict_i(branch_mispredict_i),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallFetch(StallFetch), .StallDecode(StallDecode),
    .StallExecute(StallExecute), .StallMemory(StallMemory),
    .FlushDecode(FlushDecode), .FlushExecute(FlushExecute),
    .FlushMemory(FlushMemory), .FlushWriteback(FlushWriteback),
    .pc_redirect_o(pc_redirect_o), .MduBusy(MduBusy),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  // Mispredicts are never legal while the MDU occupies Execute.
  always @(posedge clk) begin
    if (!rst) assert (!(branch_mispredict_i && MduBusy))
      else $error("illegal mispredict while MduBusy");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    MduStartE = 0; CacheStall = 0; branch_mispredict_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    #2;
    do_reset();
    #2;
    chk("rst_busy",   32'(MduBusy), 0);
    chk("rst_scnt",   32'(StallCount), 0);
    chk("rst_fcnt",   32'(FlushCount), 0);
    chk("rst_sf",     32'(StallFetch), 0);

    // Forwarding
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs2E = 9;
    #1 chk("fwdA_m", 32'(ForwardAE), 32'h2);
    chk("fwdB_none", 32'(ForwardBE), 0);
    RegWriteM = 0;
    #1 chk("fwdA_w", 32'(ForwardAE), 32'h1);
    Rs1E = 0;
    #1 chk("fwdA_x0", 32'(ForwardAE), 0);
    Rs2E = 5; RegWriteM = 1;
    #1 chk("fwdB_m", 32'(ForwardBE), 32'h2);

    // Load-use, LOAD_USE_STALL=2
    do_reset();
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    #2 chk("lu_t_sf", 32'(StallFetch), 1);
    chk("lu_t_sd", 32'(StallDecode), 1);
    chk("lu_t_fe", 32'(FlushExecute), 1);
    tick();
    ResultSrcE = 0; RdE = 0;
    #2 chk("lu_t1_sf", 32'(StallFetch), 1);
    chk("lu_t1_fe", 32'(FlushExecute), 1);
    tick();
    #2 chk("lu_t2_sf", 32'(StallFetch), 0);
    chk("lu_t2_fe", 32'(FlushExecute), 0);
    chk("lu_scnt", 32'(StallCount), 2);

    // MDU, MDU_LAT=4
    do_reset();
    MduStartE = 1;
    #2 chk("mdu_t_se", 32'(StallExecute), 1);
    chk("mdu_t_fm", 32'(FlushMemory), 1);
    chk("mdu_t_busy", 32'(MduBusy), 0);
    tick();
    #2 chk("mdu_t1_se", 32'(StallExecute), 1);
    chk("mdu_t1_busy", 32'(MduBusy), 1);
    tick();
    #2 chk("mdu_t2_se", 32'(StallExecute), 1);
    tick();
    #2 chk("mdu_t3_se", 32'(StallExecute), 0);
    chk("mdu_t3_busy", 32'(MduBusy), 1);
    tick();
    MduStartE = 0;
    #2 chk("mdu_t4_busy", 32'(MduBusy), 0);
    chk("mdu_scnt", 32'(StallCount), 3);

    // MDU with a 3-cycle cache freeze starting at t+1
    do_reset();
    MduStartE = 1;
    tick();
    CacheStall = 1;
    #2 chk("frz_sm", 32'(StallMemory), 1);
    chk("frz_fw", 32'(FlushWriteback), 1);
    chk("frz_fm", 32'(FlushMemory), 0);
    tick();
    tick();
    #2 chk("frz_t3_fw", 32'(FlushWriteback), 1);
    tick();
    CacheStall = 0;
    #2 chk("frz_t4_se", 32'(StallExecute), 1);
    chk("frz_t4_fw", 32'(FlushWriteback), 0);
    tick();
    #2 chk("frz_t5_se", 32'(StallExecute), 1);
    tick();
    #2 chk("frz_t6_se", 32'(StallExecute), 0);
    chk("frz_t6_busy", 32'(MduBusy), 1);
    chk("frz_scnt", 32'(StallCount), 6);
    tick();
    MduStartE = 0;
    #2 chk("frz_t7_busy", 32'(MduBusy), 0);

    // Mispredict together with load-use detection
    do_reset();
    branch_mispredict_i = 1; ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
    #2 chk("mp_redir", 32'(pc_redirect_o), 1);
    chk("mp_fd", 32'(FlushDecode), 1);
    chk("mp_fe", 32'(FlushExecute), 1);
    chk("mp_sf", 32'(StallFetch), 0);
    tick();
    clear_inputs();
    #2 chk("mp_lcnt_clr", 32'(StallFetch), 0);
    chk("mp_fcnt", 32'(FlushCount), 1);

    // Taken branch flushes without redirect
    PCSrcE = 2'b01;
    #1 chk("br_fd", 32'(FlushDecode), 1);
    chk("br_redir", 32'(pc_redirect_o), 0);
    PCSrcE = 0;

    // Async reset mid-MDU when mcnt=1
    do_reset();
    MduStartE = 1;
    tick();
    tick();
    #2 chk("ar_pre_se", 32'(StallExecute), 1);
    rst = 1'b1;
    #1 chk("ar_se", 32'(StallExecute), 0);
    chk("ar_sf", 32'(StallFetch), 0);
    chk("ar_busy", 32'(MduBusy), 0);
    chk("ar_scnt", 32'(StallCount), 0);
    tick();
    MduStartE = 0;
    rst = 1'b0;
    #2 chk("ar_idle", 32'(MduBusy), 0);

    // Stall counter saturation (CNT_W=4)
    CacheStall = 1;
    for (int i = 0; i < 17; i++) tick();
    #2 chk("sat_scnt", 32'(StallCount), 32'hF);
    tick();
    #2 chk("sat_hold", 32'(StallCount), 32'hF);
    CacheStall = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
